// File: rtl/router_pkg.sv
// router_pkg
//   Shared definitions for the mesh endpoint: flit header layout helpers and
//   the TX handshake state enum.
//   - hdr_lsb : bit offset of the destination header inside a flit
//   - hdr_dst : extracts {dst_x, dst_y} from a flit, zero-extended
//   - ep_state_e : TX FSM states (IDLE, WAIT_ACK)
package router_pkg;

  // Widest flit / header the helpers accept; callers zero-extend into these.
  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_HDR_W  = 32;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } ep_state_e;

  // Header occupies the top 2*coord_w bits; dst_x is the upper field.
  function automatic int unsigned hdr_lsb(input int unsigned data_w,
                                          input int unsigned coord_w);
    return data_w - 2 * coord_w;
  endfunction

  function automatic logic [MAX_HDR_W-1:0] hdr_dst(input logic [MAX_DATA_W-1:0] flit,
                                                   input int unsigned data_w,
                                                   input int unsigned coord_w);
    logic [MAX_DATA_W-1:0] shifted;
    shifted = flit >> hdr_lsb(data_w, coord_w);
    return shifted[MAX_HDR_W-1:0] &
           ((MAX_HDR_W'(1) << (2 * coord_w)) - MAX_HDR_W'(1));
  endfunction

endpackage

// File: rtl/endpoint_fifo.sv
// endpoint_fifo
//   Synchronous first-word-fall-through FIFO.
//   Ports: clk, rst_n (async active-low), push_i/wdata_i (write side),
//          pop_i/rdata_o (read side, rdata_o = head, 0 when empty),
//          full_o, empty_o.
//   Push into a full FIFO and pop from an empty one are ignored. A push is
//   visible at the head only on the following cycle.
module endpoint_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             push_en, pop_en;

  // Extra pointer MSB distinguishes full (wrapped once) from empty.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // NOTE: storage is not reset; empty entries are never observed because the
  // head output is forced to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/noc_endpoint.sv
// noc_endpoint
//   Processor-side network interface between a local valid/ready stream and a
//   two-phase (toggle) req/ack router port.
//   Ports:
//     tx_valid/tx_ready/tx_data          local injection stream
//     net_out_req/net_out_ack/net_out_data  toggle handshake toward the router
//     net_in_req/net_in_ack/net_in_data     toggle handshake from the router
//     rx_valid/rx_ready/rx_data          local ejection stream (FWFT)
//     rx_misroute                        1-cycle pulse on header mismatch
//     tx_count/rx_count                  wrapping traffic counters
module noc_endpoint
  import router_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned COORD_W     = 2,
  parameter int unsigned MY_X        = 0,
  parameter int unsigned MY_Y        = 0,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic [DATA_W-1:0]  tx_data,
  output logic               net_out_req,
  input  logic               net_out_ack,
  output logic [DATA_W-1:0]  net_out_data,
  input  logic               net_in_req,
  output logic               net_in_ack,
  input  logic [DATA_W-1:0]  net_in_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic [DATA_W-1:0]  rx_data,
  output logic               rx_misroute,
  output logic [COUNT_W-1:0] tx_count,
  output logic [COUNT_W-1:0] rx_count
);

  localparam logic [2*COORD_W-1:0] MY_HDR = {COORD_W'(MY_X), COORD_W'(MY_Y)};

  // ---------------- injection path ----------------
  logic              inj_full, inj_empty, inj_pop;
  logic [DATA_W-1:0] inj_head;

  endpoint_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_inj_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid && !inj_full),
    .wdata_i (tx_data),
    .pop_i   (inj_pop),
    .rdata_o (inj_head),
    .full_o  (inj_full),
    .empty_o (inj_empty)
  );

  assign tx_ready = !inj_full;

  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  ep_state_e              state_q;
  logic                   out_req_q;
  logic [DATA_W-1:0]      out_data_q;
  logic [COUNT_W-1:0]     tx_count_q;

  assign ack_s   = ack_sync_q[SYNC_STAGES-1];
  // Transfer completes once the synchronized ack has caught up with req.
  assign inj_pop = (state_q == WAIT_ACK) && (ack_s == out_req_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync_q <= '0;
      state_q    <= IDLE;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      tx_count_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], net_out_ack};
      case (state_q)
        IDLE: begin
          if (!inj_empty) begin
            out_data_q <= inj_head;
            out_req_q  <= ~out_req_q;
            state_q    <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (inj_pop) begin
            tx_count_q <= tx_count_q + COUNT_W'(1);
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign net_out_req  = out_req_q;
  assign net_out_data = out_data_q;
  assign tx_count     = tx_count_q;

  // ---------------- ejection path ----------------
  logic [SYNC_STAGES-1:0] req_sync_q;
  logic                   in_ack_q;
  logic                   misroute_q;
  logic [COUNT_W-1:0]     rx_count_q;
  logic                   ej_full, ej_empty;
  logic                   rx_pending, rx_accept, hdr_mismatch;

  // A new req phase is pending until our ack toggles to match it.
  assign rx_pending   = (req_sync_q[SYNC_STAGES-1] != in_ack_q);
  assign rx_accept    = rx_pending && !ej_full;
  assign hdr_mismatch = hdr_dst(MAX_DATA_W'(net_in_data), DATA_W, COORD_W)
                        != MAX_HDR_W'(MY_HDR);

  endpoint_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_ej_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rx_accept),
    .wdata_i (net_in_data),
    .pop_i   (rx_ready),
    .rdata_o (rx_data),
    .full_o  (ej_full),
    .empty_o (ej_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync_q <= '0;
      in_ack_q   <= 1'b0;
      misroute_q <= 1'b0;
      rx_count_q <= '0;
    end else begin
      req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], net_in_req};
      misroute_q <= rx_accept && hdr_mismatch;
      if (rx_accept) begin
        in_ack_q   <= ~in_ack_q;
        rx_count_q <= rx_count_q + COUNT_W'(1);
      end
    end
  end

  assign rx_valid    = !ej_empty;
  assign net_in_ack  = in_ack_q;
  assign rx_misroute = misroute_q;
  assign rx_count    = rx_count_q;

endmodule
